// File: rtl/viterbi_byte_pack.sv
// viterbi_byte_pack: takes 128-bit decoded blocks and turns them into a byte
// stream with a valid/ready handshake. Blocks wait in a 2-entry FIFO. A tail
// block carries a bit count that trims the final byte of the frame. The
// output side is a two-state FSM (IDLE/SEND) that walks a byte index across
// the head entry. Every output is driven from a register.
module viterbi_byte_pack (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] decode_out,
  input  logic         decode_out_v,
  input  logic         tail_v,
  input  logic [7:0]   tail_length,
  output logic [7:0]   byte_out,
  output logic         byte_v,
  input  logic         byte_rdy,
  output logic         byte_last,
  output logic [1:0]   buf_cnt,
  output logic         ovf,
  output logic         proto_err
);

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   nbytes;
    logic         last;
  } ent_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state_q, state_n;
  logic [3:0]   idx_q, idx_n;
  logic         sel_n;
  logic         free;
  logic         at_end;
  ent_t         fifo_q [2];
  ent_t         head, nxt_ent, wr_ent;
  logic         wr_ptr_q, rd_ptr_q;
  logic         wr_en;
  logic [8:0]   l_eff;
  logic [127:0] mask;
  logic [7:0]   byte_out_n;
  logic         byte_v_n, byte_last_n;

  assign head   = fifo_q[rd_ptr_q];
  assign at_end = ({1'b0, idx_q} == (head.nbytes - 5'd1));

  // Build the entry to store. A tail length of 0 or above 128 means a full
  // block. Bits at L and above are zeroed so the last byte pads with zeros.
  // A full FIFO still takes a write when the head is freed on the same edge.
  always_comb begin
    l_eff = (tail_length == 8'd0 || tail_length > 8'd128) ? 9'd128 : {1'b0, tail_length};
    mask  = '1;
    if (l_eff != 9'd128) mask = (128'd1 << l_eff) - 128'd1;
    wr_ent = '0;
    if (tail_v) begin
      wr_ent.data   = decode_out & mask;
      wr_ent.nbytes = 5'((l_eff + 9'd7) >> 3);
      wr_ent.last   = 1'b1;
    end else begin
      wr_ent.data   = decode_out;
      wr_ent.nbytes = 5'd16;
      wr_ent.last   = 1'b0;
    end
    wr_en = decode_out_v && (buf_cnt != 2'd2 || free);
  end

  // FSM state and byte index register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  // Next state. sel_n names the entry that the next cycle presents. After the
  // last byte of the head, a second stored entry starts at once with no bubble.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    sel_n   = rd_ptr_q;
    free    = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_cnt != 2'd0) begin
          state_n = SEND;
          idx_n   = 4'd0;
        end
      end
      SEND: begin
        if (byte_rdy) begin
          if (at_end) begin
            free  = 1'b1;
            idx_n = 4'd0;
            if (buf_cnt == 2'd2) sel_n = ~rd_ptr_q;
            else                 state_n = IDLE;
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next output values. A stall keeps state, index and head unchanged, so
  // byte_out and byte_last hold their values.
  always_comb begin
    nxt_ent     = fifo_q[sel_n];
    byte_v_n    = (state_n == SEND);
    byte_out_n  = 8'd0;
    byte_last_n = 1'b0;
    if (state_n == SEND) begin
      byte_out_n  = nxt_ent.data[{idx_n, 3'b000} +: 8];
      byte_last_n = nxt_ent.last && ({1'b0, idx_n} == (nxt_ent.nbytes - 5'd1));
    end
  end

  // Output byte and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_out  <= 8'd0;
      byte_v    <= 1'b0;
      byte_last <= 1'b0;
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      byte_out  <= byte_out_n;
      byte_v    <= byte_v_n;
      byte_last <= byte_last_n;
      ovf       <= decode_out_v && !wr_en;
      proto_err <= tail_v && !decode_out_v;
    end
  end

  // FIFO pointers and occupancy. A write and a free on the same edge cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      buf_cnt  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_q <= ~wr_ptr_q;
      if (free)  rd_ptr_q <= ~rd_ptr_q;
      buf_cnt <= buf_cnt + {1'b0, wr_en} - {1'b0, free};
    end
  end

  // FIFO storage. The pointers and buf_cnt mark which entries hold valid data.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= wr_ent;
  end

endmodule

// File: tb/tb_viterbi_byte_pack.sv
// Directed bench for viterbi_byte_pack. Inputs change 1ns after the rising
// edge, and outputs are checked at that same point.
module tb_viterbi_byte_pack;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] decode_out = '0;
  logic         decode_out_v = 1'b0;
  logic         tail_v = 1'b0;
  logic [7:0]   tail_length = 8'd0;
  logic [7:0]   byte_out;
  logic         byte_v;
  logic         byte_rdy = 1'b0;
  logic         byte_last;
  logic [1:0]   buf_cnt;
  logic         ovf;
  logic         proto_err;

  int total = 0;
  int bad   = 0;

  viterbi_byte_pack dut (
    .clk(clk), .rst(rst),
    .decode_out(decode_out), .decode_out_v(decode_out_v),
    .tail_v(tail_v), .tail_length(tail_length),
    .byte_out(byte_out), .byte_v(byte_v), .byte_rdy(byte_rdy),
    .byte_last(byte_last), .buf_cnt(buf_cnt), .ovf(ovf), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block for a single edge
  task automatic wr_block(input logic [127:0] d, input logic tl, input logic [7:0] len);
    decode_out = d; decode_out_v = 1'b1; tail_v = tl; tail_length = len;
    tick();
    decode_out_v = 1'b0; tail_v = 1'b0;
  endtask

  // Take n bytes. pat sets byte_rdy for each cycle; byte_v has to stay high.
  task automatic drain(input logic [127:0] exp, input int n, input logic has_last,
                       input logic [31:0] pat);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 200) begin
      byte_rdy = (cyc < 32) ? pat[cyc] : 1'b1;
      if (byte_v) begin
        chk("byte", byte_out, exp[8*k +: 8]);
        chk("last", byte_last, has_last && (k == n - 1));
        if (byte_rdy) k++;
      end else begin
        chk("vld", byte_v, 1);
      end
      tick();
      cyc++;
    end
    chk("drain_cnt", k, n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"}, byte_v, 0);
    chk({tag, "_cnt"}, buf_cnt, 0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_v", byte_v, 0);
    chk("rst_cnt", buf_cnt, 0);
    chk("rst_out", byte_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_perr", proto_err, 0);
    tick();
    rst = 1'b1;

    // full block, 16 bytes back to back, first byte two edges after the write
    byte_rdy = 1'b1;
    wr_block(ramp(8'h00), 1'b0, 8'd0);
    chk("full_cnt", buf_cnt, 1);
    chk("full_lat", byte_v, 0);
    tick();
    drain(ramp(8'h00), 16, 1'b0, '1);
    chk_idle("full_end");

    // tail of 20 bits: FF FF 0F
    wr_block('1, 1'b1, 8'd20);
    tick();
    drain(128'h0FFFFF, 3, 1'b1, '1);
    chk_idle("tail20_end");

    // tail of 9 bits: FF 01
    wr_block('1, 1'b1, 8'd9);
    tick();
    drain(128'h01FF, 2, 1'b1, '1);

    // backpressure: byte_rdy goes 1,0,0,1 and then stays high
    wr_block(ramp(8'hA0), 1'b0, 8'd0);
    tick();
    drain(ramp(8'hA0), 16, 1'b0, 32'hFFFF_FFF9);
    chk_idle("bp_end");

    // overflow: three blocks on consecutive edges with byte_rdy low
    byte_rdy = 1'b0;
    decode_out_v = 1'b1; decode_out = ramp(8'h10);
    tick();
    chk("ovf_cnt1", buf_cnt, 1);
    chk("ovf_p1", ovf, 0);
    decode_out = ramp(8'h40);
    tick();
    chk("ovf_cnt2", buf_cnt, 2);
    chk("ovf_p2", ovf, 0);
    decode_out = ramp(8'h80);
    tick();
    decode_out_v = 1'b0;
    chk("ovf_pulse", ovf, 1);
    chk("ovf_cnt3", buf_cnt, 2);
    tick();
    chk("ovf_clr", ovf, 0);
    chk("ovf_hold", byte_out, 8'h10);
    drain(ramp(8'h10), 16, 1'b0, '1);
    drain(ramp(8'h40), 16, 1'b0, '1);
    chk_idle("ovf_end");

    // full FIFO, and a write lands on the edge that takes the head's last byte
    byte_rdy = 1'b0;
    decode_out_v = 1'b1; decode_out = ramp(8'h20);
    tick();
    decode_out = ramp(8'h50);
    tick();
    decode_out_v = 1'b0;
    chk("ff_cnt", buf_cnt, 2);
    drain(ramp(8'h20), 15, 1'b0, '1);
    chk("ff_b15", byte_out, 8'h2F);
    byte_rdy = 1'b1;
    decode_out_v = 1'b1; decode_out = ramp(8'hC0);
    tick();
    decode_out_v = 1'b0;
    chk("ff_cnt_keep", buf_cnt, 2);
    chk("ff_no_ovf", ovf, 0);
    drain(ramp(8'h50), 16, 1'b0, '1);
    drain(ramp(8'hC0), 16, 1'b0, '1);
    chk_idle("ff_end");

    // tail_v with no block valid is ignored and flagged
    tail_v = 1'b1; tail_length = 8'd8;
    tick();
    tail_v = 1'b0;
    chk("perr_pulse", proto_err, 1);
    chk("perr_cnt", buf_cnt, 0);
    tick();
    chk("perr_clr", proto_err, 0);
    chk("perr_v", byte_v, 0);

    // reset mid-frame after 5 bytes, then a tail_length=0 block after release
    wr_block(ramp(8'h60), 1'b0, 8'd0);
    tick();
    drain(ramp(8'h60), 5, 1'b0, '1);
    rst = 1'b0;
    #1;
    chk("mrst_v", byte_v, 0);
    chk("mrst_cnt", buf_cnt, 0);
    chk("mrst_out", byte_out, 0);
    tick();
    rst = 1'b1;
    wr_block(ramp(8'h00), 1'b1, 8'd0);
    chk("mrst_wr", buf_cnt, 1);
    chk("mrst_lat", byte_v, 0);
    tick();
    drain(ramp(8'h00), 16, 1'b1, '1);
    chk_idle("mrst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
